ring_config_measure: RTL and testbench
======================================

Name: ring_config_measure

Overview:
- Master-side producer of ring configuration values for the ring configuration checker.
- On request it launches one discovery frame into the slave ring and times its round trip.
- It captures the returned slave ID count and computes the per-slave average delay by serial division.
- Results feed LastSlaveIDPlus1 / AveSlaveDelay of the config checker; the checker then validates them against its 1..30 and 50..70 windows.

Parameters:
- CNT_W, 16, round-trip cycle counter width.
- TIMEOUT_CYC, 16'd65000, WAIT cycles before declaring the ring broken.
- MASTER_OVERHEAD, 16'd0, fixed master TX+RX pipeline cycles subtracted from round trip.

Ports:
- Clk  input  1  system clock, rising-edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Start  input  1  one-cycle measurement request; ignored unless Busy=0.
- RxValid  input  1  one-cycle strobe: discovery frame returned to master.
- RxSlaveID  input  8  ID field of returned frame (each slave increments it; master sends 0).
- TxStart  output  1  one-cycle pulse: transmit discovery frame with ID=0.
- Busy  output  1  high from Start accept until MeasDone/Timeout.
- LastSlaveIDPlus1  output  8  captured slave count.
- AveSlaveDelay  output  8  average cycles per slave, saturated at 255.
- MeasDone  output  1  level; results valid, held until next accepted Start.
- Timeout  output  1  level; no frame returned, held until next accepted Start.

Behaviour:
- Reset (async on Reset_n=0): state IDLE; all outputs 0; counter, divider registers 0. Reset mid-operation aborts immediately. No TxStart after release until a new Start.
- FSM states: IDLE, SEND, WAIT, SUB, DIV, DONE, FAIL.
- IDLE: Start=1 -> SEND; MeasDone, Timeout cleared; Busy=1 from the next cycle.
- SEND: TxStart=1 for exactly this cycle; counter cleared to 0 -> WAIT.
- WAIT: counter +1 per cycle, saturating at all-ones. Counter holds N when RxValid arrives N cycles after the TxStart cycle.
  - RxValid=1: capture RoundTrip=N and LastSlaveIDPlus1=RxSlaveID -> SUB.
  - Counter reaching TIMEOUT_CYC without RxValid -> FAIL. If RxValid coincides with that cycle, RxValid wins.
- SUB: Num = RoundTrip - MASTER_OVERHEAD, clamped to 0 if negative.
  - LastSlaveIDPlus1 == 0: AveSlaveDelay=0 -> DONE; no divide.
  - Otherwise -> DIV.
- DIV: restoring divide, CNT_W-bit Num by 8-bit LastSlaveIDPlus1; one quotient bit per cycle; exactly CNT_W cycles; quotient truncated (floor).
  - Quotient > 255: AveSlaveDelay=8'hFF.
  - Then -> DONE.
- DONE: MeasDone=1, Busy=0 -> IDLE. Outputs hold. Latency: MeasDone rises CNT_W+2 cycles after the RxValid cycle (18 at default).
- FAIL: Timeout=1, Busy=0, LastSlaveIDPlus1=0, AveSlaveDelay=0 -> IDLE.
- Ignored inputs:
  - Start while Busy=1.
  - RxValid outside WAIT; it also has no effect on counters.
- Start arriving the same cycle DONE/FAIL returns to IDLE is not accepted; it must come while in IDLE.

Optional Feature:
- Macro RING_MEAS_AVG4_EN.
- Defined: one Start runs four SEND/WAIT rounds back-to-back.
  - RoundTrip = floor(sum of 4 round trips / 4); the accumulator is CNT_W+2 bits.
  - LastSlaveIDPlus1 comes from the final round.
  - A timeout in any round -> FAIL.
  - MeasDone latency is counted from the 4th RxValid.
- Undefined: single round as described above.

Test Plan:
- Start; RxValid with RxSlaveID=10 exactly 600 cycles after TxStart -> LastSlaveIDPlus1=10, AveSlaveDelay=60, MeasDone 18 cycles after RxValid, Busy low.
- Start; no RxValid -> Timeout=1 after 65000 WAIT cycles, outputs 0, MeasDone=0.
- RxSlaveID=0, round trip 40 -> AveSlaveDelay=0, MeasDone=1, no divide cycles (MeasDone 2 cycles after RxValid).
- RxSlaveID=1, round trip 400 -> AveSlaveDelay=255 (saturated); RxSlaveID=7, round trip 500 -> 71.
- Reset_n pulsed low during DIV -> all outputs 0 asynchronously. Extra Start pulses while Busy -> exactly one TxStart per accepted Start.
- RING_MEAS_AVG4_EN, round trips 598/600/602/604, ID=10 -> RoundTrip=601, AveSlaveDelay=60, four TxStart pulses.

Source files
------------

// File: rtl/ring_config_measure.sv
// Ring configuration measurement: launches a discovery frame, times its round trip and
// divides by the returned slave count. Optional macro RING_MEAS_AVG4_EN averages four rounds.
module ring_config_measure #(
   parameter int              CNT_W           = 16,
   parameter logic [CNT_W-1:0] TIMEOUT_CYC     = 16'd65000,
   parameter logic [CNT_W-1:0] MASTER_OVERHEAD = 16'd0
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       Start,
   input  logic       RxValid,
   input  logic [7:0] RxSlaveID,
   output logic       TxStart,
   output logic       Busy,
   output logic [7:0] LastSlaveIDPlus1,
   output logic [7:0] AveSlaveDelay,
   output logic       MeasDone,
   output logic       Timeout
);

   localparam int BIT_W = $clog2(CNT_W + 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_SEND = 3'd1,
      S_WAIT = 3'd2,
      S_SUB  = 3'd3,
      S_DIV  = 3'd4,
      S_DONE = 3'd5,
      S_FAIL = 3'd6
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] quo_q, quo_d;
   logic [7:0]       rem_q, rem_d;
   logic [BIT_W-1:0] bit_q, bit_d;
   logic             tx_start_q, tx_start_d;
   logic             busy_q, busy_d;
   logic [7:0]       last_q, last_d;
   logic [7:0]       ave_q, ave_d;
   logic             done_q, done_d;
   logic             timeout_q, timeout_d;
`ifdef RING_MEAS_AVG4_EN
   logic [1:0]       round_q, round_d;
   logic [CNT_W+1:0] acc_q, acc_d;
   logic [CNT_W+1:0] acc_sum_s;
`endif

   logic [CNT_W-1:0] elapsed_s;
   logic [8:0]       trial_s;
   logic             ge_s;
   logic [8:0]       rem_sub_s;
   logic [CNT_W-1:0] q_fin_s;

   // Next-state, datapath and output computation
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      quo_d      = quo_q;
      rem_d      = rem_q;
      bit_d      = bit_q;
      tx_start_d = 1'b0;
      busy_d     = busy_q;
      last_d     = last_q;
      ave_d      = ave_q;
      done_d     = done_q;
      timeout_d  = timeout_q;
`ifdef RING_MEAS_AVG4_EN
      round_d    = round_q;
      acc_d      = acc_q;
`endif

      // elapsed_s is the number of cycles since the TxStart cycle
      elapsed_s = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
`ifdef RING_MEAS_AVG4_EN
      acc_sum_s = acc_q + {2'b00, elapsed_s};
`endif
      trial_s   = {rem_q, quo_q[CNT_W-1]};
      ge_s      = (trial_s >= {1'b0, last_q});
      rem_sub_s = ge_s ? (trial_s - {1'b0, last_q}) : trial_s;
      q_fin_s   = {quo_q[CNT_W-2:0], ge_s};

      case (state_q)
         S_IDLE: begin
            if (Start) begin
               state_d    = S_SEND;
               tx_start_d = 1'b1;
               busy_d     = 1'b1;
               done_d     = 1'b0;
               timeout_d  = 1'b0;
`ifdef RING_MEAS_AVG4_EN
               round_d    = 2'd0;
               acc_d      = {(CNT_W+2){1'b0}};
`endif
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SEND: begin
            cnt_d   = {CNT_W{1'b0}};
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (RxValid) begin
               last_d = RxSlaveID;
`ifdef RING_MEAS_AVG4_EN
               acc_d = acc_sum_s;
               if (round_q == 2'd3) begin
                  quo_d   = acc_sum_s[CNT_W+1:2];
                  state_d = S_SUB;
               end else begin
                  round_d    = round_q + 2'd1;
                  tx_start_d = 1'b1;
                  state_d    = S_SEND;
               end
`else
               quo_d   = elapsed_s;
               state_d = S_SUB;
`endif
            end else if (elapsed_s >= TIMEOUT_CYC) begin
               state_d   = S_FAIL;
               timeout_d = 1'b1;
               busy_d    = 1'b0;
               last_d    = 8'd0;
               ave_d     = 8'd0;
            end else begin
               cnt_d = elapsed_s;
            end
         end
         S_SUB: begin
            quo_d = (quo_q > MASTER_OVERHEAD) ? (quo_q - MASTER_OVERHEAD) : {CNT_W{1'b0}};
            rem_d = 8'd0;
            bit_d = {BIT_W{1'b0}};
            if (last_q == 8'd0) begin
               ave_d   = 8'd0;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_DONE;
            end else begin
               state_d = S_DIV;
            end
         end
         S_DIV: begin
            rem_d = rem_sub_s[7:0];
            quo_d = q_fin_s;
            bit_d = bit_q + BIT_W'(1);
            if (bit_q == BIT_W'(CNT_W - 1)) begin
               ave_d   = (|q_fin_s[CNT_W-1:8]) ? 8'hFF : q_fin_s[7:0];
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_DONE;
            end else begin
               state_d = S_DIV;
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_FAIL:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= {CNT_W{1'b0}};
         quo_q      <= {CNT_W{1'b0}};
         rem_q      <= 8'd0;
         bit_q      <= {BIT_W{1'b0}};
         tx_start_q <= 1'b0;
         busy_q     <= 1'b0;
         last_q     <= 8'd0;
         ave_q      <= 8'd0;
         done_q     <= 1'b0;
         timeout_q  <= 1'b0;
`ifdef RING_MEAS_AVG4_EN
         round_q    <= 2'd0;
         acc_q      <= {(CNT_W+2){1'b0}};
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         quo_q      <= quo_d;
         rem_q      <= rem_d;
         bit_q      <= bit_d;
         tx_start_q <= tx_start_d;
         busy_q     <= busy_d;
         last_q     <= last_d;
         ave_q      <= ave_d;
         done_q     <= done_d;
         timeout_q  <= timeout_d;
`ifdef RING_MEAS_AVG4_EN
         round_q    <= round_d;
         acc_q      <= acc_d;
`endif
      end
   end

   assign TxStart          = tx_start_q;
   assign Busy             = busy_q;
   assign LastSlaveIDPlus1 = last_q;
   assign AveSlaveDelay    = ave_q;
   assign MeasDone         = done_q;
   assign Timeout          = timeout_q;

endmodule

// File: tb/tb_ring_config_measure.sv
// Randomized bench for ring_config_measure with a cycle-scheduled reference model;
// honours RING_MEAS_AVG4_EN by averaging four rounds in the model.
module tb_ring_config_measure;

   localparam int CNT_W   = 16;
   localparam int TIMEOUT = 65000;
   localparam int OH      = 0;
`ifdef RING_MEAS_AVG4_EN
   localparam int NR = 4;
`else
   localparam int NR = 1;
`endif

   logic       Clk = 1'b0;
   logic       Reset_n;
   logic       Start;
   logic       RxValid;
   logic [7:0] RxSlaveID;
   logic       TxStart;
   logic       Busy;
   logic [7:0] LastSlaveIDPlus1;
   logic [7:0] AveSlaveDelay;
   logic       MeasDone;
   logic       Timeout;

   int cyc = 0;
   int n_chk = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   // Model: schedule of the current measurement plus results visible before it
   int m_T0, m_D, m_kind, m_last, m_ave;
   int p_kind, p_last, p_ave;
   int m_tx[4];

   ring_config_measure dut (
      .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .RxValid(RxValid),
      .RxSlaveID(RxSlaveID), .TxStart(TxStart), .Busy(Busy),
      .LastSlaveIDPlus1(LastSlaveIDPlus1), .AveSlaveDelay(AveSlaveDelay),
      .MeasDone(MeasDone), .Timeout(Timeout)
   );

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic reset_model();
      p_kind = 0; p_last = 0; p_ave = 0;
      m_kind = 0; m_last = 0; m_ave = 0;
      m_T0 = 32'h7fff_ffff; m_D = 32'h7fff_ffff;
      for (int k = 0; k < 4; k++) m_tx[k] = -1;
   endtask

   // Every cycle: outputs against the model schedule
   always @(negedge Clk) begin
      if (chk_en) begin
         bit nw;
         bit e_tx;
         int ek, el, ea;
         nw = (cyc >= m_T0);
         e_tx = 1'b0;
         for (int k = 0; k < 4; k++) if (m_tx[k] == cyc) e_tx = 1'b1;
         ek = nw ? ((cyc >= m_D) ? m_kind : 0) : p_kind;
         el = nw ? m_last : p_last;
         ea = nw ? m_ave : p_ave;
         chk("TxStart", TxStart, e_tx);
         chk("Busy", Busy, nw && (cyc < m_D));
         chk("MeasDone", MeasDone, ek == 1);
         chk("Timeout", Timeout, ek == 2);
         if (ek != 0) begin
            chk("LastSlaveIDPlus1", LastSlaveIDPlus1, el);
            chk("AveSlaveDelay", AveSlaveDelay, ea);
         end
      end
   end

   task automatic step(input bit sn, input bit rn, input int idv);
      Start = sn;
      RxValid = rn;
      RxSlaveID = 8'(idv);
      @(negedge Clk); #1;
      Start = 1'b0;
      RxValid = 1'b0;
   endtask

   task automatic run_meas(input int n0, input int n1, input int n2, input int n3,
                           input int id, input bit to, input int lit, input int abort,
                           input bit noise);
      int ns[4];
      int rr[4];
      int c, t, sum, rt, num, q;
      ns[0] = n0; ns[1] = n1; ns[2] = n2; ns[3] = n3;
      c = cyc;
      if (c >= m_T0) begin
         p_kind = m_kind; p_last = m_last; p_ave = m_ave;
      end
      for (int k = 0; k < 4; k++) m_tx[k] = -1;
      m_T0 = c + 1;
      if (to) begin
         m_tx[0] = c + 1;
         m_D = c + 1 + TIMEOUT + 1;
         m_kind = 2; m_last = 0; m_ave = 0;
      end else begin
         t = c + 1;
         sum = 0;
         for (int k = 0; k < NR; k++) begin
            m_tx[k] = t;
            rr[k] = t + ns[k];
            sum += ns[k];
            t = rr[k] + 1;
         end
         rt = sum / NR;
         num = (rt > OH) ? rt - OH : 0;
         m_last = id;
         if (id == 0) m_ave = 0;
         else begin
            q = num / id;
            m_ave = (q > 255) ? 255 : q;
         end
         m_D = rr[NR-1] + ((id == 0) ? 2 : CNT_W + 2);
         m_kind = 1;
      end
      step(1'b1, 1'b0, 0);
      if (!to) begin
         for (int k = 0; k < NR; k++) begin
            while (cyc < rr[k]) step(noise && ($urandom_range(0, 5) == 0), 1'b0, $urandom_range(0, 255));
            step(1'b0, 1'b1, (k == NR - 1) ? id : $urandom_range(0, 255));
         end
         if (abort > 0) begin
            while (cyc < rr[NR-1] + abort) step(1'b0, 1'b0, 0);
            chk_en = 1'b0;
            #1 Reset_n = 1'b0;
            #1;
            chk("rst_TxStart", TxStart, 0);
            chk("rst_Busy", Busy, 0);
            chk("rst_Last", LastSlaveIDPlus1, 0);
            chk("rst_Ave", AveSlaveDelay, 0);
            chk("rst_MeasDone", MeasDone, 0);
            chk("rst_Timeout", Timeout, 0);
            @(negedge Clk); #1;
            Reset_n = 1'b1;
            reset_model();
            chk_en = 1'b1;
            repeat (4) step(1'b0, 1'b0, 0);
            return;
         end
      end
      while (cyc < m_D)
         step(noise && ($urandom_range(0, 5) == 0),
              !to && noise && ($urandom_range(0, 5) == 0), $urandom_range(0, 255));
      if (lit >= 0) chk("lit_AveSlaveDelay", AveSlaveDelay, lit);
      step(noise, 1'b0, 0);
      repeat (2) step(1'b0, noise, $urandom_range(0, 255));
   endtask

   initial begin
      Reset_n = 1'b0;
      Start = 1'b0;
      RxValid = 1'b0;
      RxSlaveID = 8'd0;
      reset_model();
      repeat (3) @(negedge Clk);
      chk("reset_TxStart", TxStart, 0);
      chk("reset_Busy", Busy, 0);
      chk("reset_MeasDone", MeasDone, 0);
      chk("reset_Timeout", Timeout, 0);
      chk("reset_Last", LastSlaveIDPlus1, 0);
      chk("reset_Ave", AveSlaveDelay, 0);
      #1 Reset_n = 1'b1;
      chk_en = 1'b1;
      repeat (3) step(1'b0, 1'b0, 0);

      run_meas(600, 598, 602, 604, 10, 1'b0, 60, 0, 1'b1);
      run_meas(40, 40, 40, 40, 0, 1'b0, 0, 0, 1'b1);
      run_meas(400, 400, 400, 400, 1, 1'b0, 255, 0, 1'b1);
      run_meas(500, 500, 500, 500, 7, 1'b0, 71, 0, 1'b1);
      run_meas(0, 0, 0, 0, 0, 1'b1, 0, 0, 1'b1);
      run_meas(300, 300, 300, 300, 3, 1'b0, -1, 0, 1'b0);
      run_meas(500, 500, 500, 500, 7, 1'b0, -1, 6, 1'b1);

      for (int i = 0; i < 20; i++) begin
         int id;
         id = (i % 5 == 0) ? $urandom_range(1, 3) : $urandom_range(0, 255);
         if (i % 7 == 3) id = 0;
         run_meas($urandom_range(1, 400), $urandom_range(1, 400), $urandom_range(1, 400),
                  $urandom_range(1, 400), id, 1'b0, -1, 0, 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
